// File: rtl/prbs_multi_checker.sv
// Multi-lane self-synchronising PRBS checker: each 32-bit lane predicts its next word from the
// last received word, hunts for lock, and accumulates saturating word and bit-error counts.
module prbs_multi_checker #(
  parameter int unsigned N_CHANNELS   = 1,
  parameter logic [31:0] POLY         = 32'h80000057,
  parameter int unsigned ITERATIONS   = 32,
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [32*N_CHANNELS-1:0]        S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            clear_counters,
  output logic [N_CHANNELS-1:0]           locked,
  output logic [N_CHANNELS-1:0]           error_flag,
  output logic [CNT_WIDTH*N_CHANNELS-1:0] word_count,
  output logic [CNT_WIDTH*N_CHANNELS-1:0] bit_error_count
);

  typedef enum logic [1:0] {StIdle, StHunt, StLocked} state_e;

  function automatic logic [31:0] advance(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < int'(ITERATIONS); i++) begin
      v = {v[30:0], ^(v & POLY)};
    end
    return v;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, x[i]};
    end
    return c;
  endfunction

  assign S_AXIS_TREADY = 1'b1;

  for (genvar j = 0; j < int'(N_CHANNELS); j++) begin : g_lane
    state_e                 state_q;
    logic [31:0]            pred_q;
    logic [7:0]             match_q;
    logic [7:0]             miss_q;
    logic [CNT_WIDTH-1:0]   words_q;
    logic [CNT_WIDTH-1:0]   biterr_q;
    logic                   err_q;
    logic [31:0]            rx;
    logic                   mismatch;
    logic [5:0]             nbits;
    logic [CNT_WIDTH:0]     bit_sum;

    assign rx       = S_AXIS_TDATA[32*j +: 32];
    assign mismatch = (rx != pred_q);
    assign nbits    = popcount32(rx ^ pred_q);
    assign bit_sum  = {1'b0, biterr_q} + {{(CNT_WIDTH-5){1'b0}}, nbits};

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= StIdle;
        pred_q   <= 32'hFFFF_FFFF;
        match_q  <= '0;
        miss_q   <= '0;
        words_q  <= '0;
        biterr_q <= '0;
        err_q    <= 1'b0;
      end else begin
        err_q <= 1'b0;
        if (S_AXIS_TVALID) begin
          // Prediction always reseeds from the received word, never from itself.
          pred_q <= advance(rx);
          unique case (state_q)
            StIdle: state_q <= StHunt;
            StHunt: begin
              if (mismatch) begin
                match_q <= '0;
              end else if (match_q == 8'(LOCK_COUNT - 1)) begin
                state_q <= StLocked;
                match_q <= '0;
              end else begin
                match_q <= match_q + 8'd1;
              end
            end
            StLocked: begin
              if (mismatch) begin
                err_q <= 1'b1;
                if (miss_q == 8'(UNLOCK_COUNT - 1)) begin
                  state_q <= StHunt;
                  miss_q  <= '0;
                  match_q <= '0;
                end else begin
                  miss_q <= miss_q + 8'd1;
                end
              end else begin
                miss_q <= '0;
              end
              if (!clear_counters) begin
                if (words_q != '1) words_q <= words_q + CNT_WIDTH'(1);
                biterr_q <= bit_sum[CNT_WIDTH] ? '1 : bit_sum[CNT_WIDTH-1:0];
              end
            end
            default: state_q <= StIdle;
          endcase
        end
        if (clear_counters) begin
          words_q  <= '0;
          biterr_q <= '0;
        end
      end
    end

    assign locked[j]                                 = (state_q == StLocked);
    assign error_flag[j]                             = err_q;
    assign word_count[CNT_WIDTH*j +: CNT_WIDTH]      = words_q;
    assign bit_error_count[CNT_WIDTH*j +: CNT_WIDTH] = biterr_q;
  end

endmodule

// File: tb/tb_prbs_multi_checker.sv
// Bench for prbs_multi_checker: four lanes, 8-bit counters, randomized stimulus checked
// against a per-lane behavioural model every cycle plus targeted scenario checks.
module tb_prbs_multi_checker;
  localparam int          NCH  = 4;
  localparam int          CW   = 8;
  localparam logic [31:0] POLY = 32'h80000057;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                tvalid = 1'b0;
  logic                tready;
  logic                clr = 1'b0;
  logic [32*NCH-1:0]   tdata = '0;
  logic [NCH-1:0]      locked;
  logic [NCH-1:0]      error_flag;
  logic [CW*NCH-1:0]   word_count;
  logic [CW*NCH-1:0]   bit_error_count;

  always #5 clk = ~clk;

  prbs_multi_checker #(
    .N_CHANNELS  (NCH),
    .POLY        (POLY),
    .ITERATIONS  (32),
    .LOCK_COUNT  (16),
    .UNLOCK_COUNT(4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TVALID  (tvalid),
    .S_AXIS_TREADY  (tready),
    .clear_counters (clr),
    .locked         (locked),
    .error_flag     (error_flag),
    .word_count     (word_count),
    .bit_error_count(bit_error_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Clean PRBS generator per lane and reference model state.
  logic [31:0] gen     [NCH];
  int          m_state [NCH];  // 0 idle, 1 hunt, 2 locked
  logic [31:0] m_pred  [NCH];
  int          m_match [NCH];
  int          m_miss  [NCH];
  int          m_words [NCH];
  int          m_bits  [NCH];
  logic        m_err   [NCH];

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    repeat (32) v = (v << 1) | 32'($countones(v & POLY) % 2);
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic model_beat(input int j, input logic [31:0] r, input logic c);
    int nb;
    nb = $countones(r ^ m_pred[j]);
    case (m_state[j])
      0: m_state[j] = 1;
      1: begin
        if (r == m_pred[j]) begin
          m_match[j]++;
          if (m_match[j] == 16) begin
            m_state[j] = 2;
            m_match[j] = 0;
          end
        end else m_match[j] = 0;
      end
      default: begin
        if (!c) begin
          m_words[j] = sat(m_words[j] + 1);
          m_bits[j]  = sat(m_bits[j] + nb);
        end
        if (r != m_pred[j]) begin
          m_err[j] = 1'b1;
          m_miss[j]++;
          if (m_miss[j] == 4) begin
            m_state[j] = 1;
            m_miss[j]  = 0;
            m_match[j] = 0;
          end
        end else m_miss[j] = 0;
      end
    endcase
    m_pred[j] = prbs_next(r);
  endtask

  // One clock: drive clean stream XOR xm, advance model, compare every lane output.
  task automatic step(input logic v, input logic c, input logic rst, input logic [32*NCH-1:0] xm);
    logic [31:0] w [NCH];
    for (int j = 0; j < NCH; j++) begin
      w[j] = gen[j] ^ xm[32*j +: 32];
      tdata[32*j +: 32] = w[j];
    end
    tvalid = v;
    clr    = c;
    reset  = rst;
    @(posedge clk);
    #1;
    for (int j = 0; j < NCH; j++) begin
      m_err[j] = 1'b0;
      if (rst) begin
        m_state[j] = 0; m_pred[j] = 32'hFFFF_FFFF; m_match[j] = 0; m_miss[j] = 0;
        m_words[j] = 0; m_bits[j] = 0;
      end else begin
        if (v) model_beat(j, w[j], c);
        if (c) begin
          m_words[j] = 0;
          m_bits[j]  = 0;
        end
      end
      if (v) gen[j] = prbs_next(gen[j]);
    end
    for (int j = 0; j < NCH; j++) begin
      vectors++;
      if (locked[j] !== (m_state[j] == 2)) begin
        miscompares++;
        $display("FAIL model_locked lane %0d t=%0t: got %b want %b", j, $time, locked[j],
                 m_state[j] == 2);
      end
      vectors++;
      if (error_flag[j] !== m_err[j]) begin
        miscompares++;
        $display("FAIL model_err lane %0d t=%0t: got %b want %b", j, $time, error_flag[j],
                 m_err[j]);
      end
      vectors++;
      if (word_count[CW*j +: CW] !== CW'(m_words[j])) begin
        miscompares++;
        $display("FAIL model_words lane %0d t=%0t: got %0d want %0d", j, $time,
                 word_count[CW*j +: CW], m_words[j]);
      end
      vectors++;
      if (bit_error_count[CW*j +: CW] !== CW'(m_bits[j])) begin
        miscompares++;
        $display("FAIL model_bits lane %0d t=%0t: got %0d want %0d", j, $time,
                 bit_error_count[CW*j +: CW], m_bits[j]);
      end
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, '0);
    vectors++;
    if (locked !== '0 || error_flag !== '0 || word_count !== '0 || bit_error_count !== '0 ||
        tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got lk=%b ef=%b wc=%h bc=%h rdy=%b want all 0, rdy 1",
               locked, error_flag, word_count, bit_error_count, tready);
    end
  endtask

  task automatic test_lock_acquire();
    gen[0] = 32'h0000_0001;
    for (int j = 1; j < NCH; j++) gen[j] = $urandom() | 32'h1;
    for (int b = 1; b <= 40; b++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (b == 16 || b == 17) begin
        vectors++;
        if (locked[0] !== (b == 17)) begin
          miscompares++;
          $display("FAIL lock_edge beat %0d: got %b want %b", b, locked[0], b == 17);
        end
      end
    end
    vectors++;
    if (word_count[7:0] !== 8'd23 || bit_error_count[7:0] !== 8'd0) begin
      miscompares++;
      $display("FAIL lock_counts: got wc=%0d bc=%0d want 23 0", word_count[7:0],
               bit_error_count[7:0]);
    end
  endtask

  task automatic test_bit_flip();
    int want_bits;
    want_bits = sat(m_bits[0] + 1);
    step(1'b1, 1'b0, 1'b0, {{(32*NCH-1){1'b0}}, 1'b1});
    vectors++;
    if (error_flag !== 4'b0001 || locked[0] !== 1'b1 || bit_error_count[7:0] !== CW'(want_bits))
    begin
      miscompares++;
      $display("FAIL bit_flip: got ef=%b lk=%b bc=%0d want ef=0001 lk=1 bc=%0d", error_flag,
               locked[0], bit_error_count[7:0], want_bits);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    vectors++;
    if (locked !== 4'hF || error_flag !== 4'h0) begin
      miscompares++;
      $display("FAIL bit_flip_recover: got lk=%b ef=%b want 1111 0000", locked, error_flag);
    end
  endtask

  task automatic test_unlock_relock();
    logic [32*NCH-1:0] xm;
    for (int i = 0; i < 4; i++) begin
      xm = '0;
      xm[31:0] = (i % 2 == 0) ? gen[0] : ~gen[0];
      step(1'b1, 1'b0, 1'b0, xm);
    end
    vectors++;
    if (locked[0] !== 1'b0 || locked[3:1] !== 3'b111) begin
      miscompares++;
      $display("FAIL unlock: got lk=%b want 1110", locked);
    end
    for (int b = 1; b <= 17; b++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (b >= 16) begin
        vectors++;
        if (locked[0] !== (b == 17)) begin
          miscompares++;
          $display("FAIL relock beat %0d: got %b want %b", b, locked[0], b == 17);
        end
      end
    end
  endtask

  task automatic test_lane_isolation();
    logic [32*NCH-1:0] xm;
    xm = '0;
    xm[64 +: 32] = $urandom() | 32'h0000_0100;
    step(1'b1, 1'b0, 1'b0, xm);
    vectors++;
    if (error_flag !== 4'b0100 || locked !== 4'hF) begin
      miscompares++;
      $display("FAIL lane_isolation: got ef=%b lk=%b want 0100 1111", error_flag, locked);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_gaps();
    logic v;
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      step(v, 1'b0, 1'b0, '0);
      if (!v) begin
        vectors++;
        if (error_flag !== 4'h0 || locked !== 4'hF) begin
          miscompares++;
          $display("FAIL gap_hold: got ef=%b lk=%b want 0000 1111", error_flag, locked);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, '0);
    vectors++;
    if (word_count !== {NCH{8'hFF}}) begin
      miscompares++;
      $display("FAIL saturate: got wc=%h want ffffffff", word_count);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    vectors++;
    if (word_count !== '0 || bit_error_count !== '0 || locked !== 4'hF) begin
      miscompares++;
      $display("FAIL clear_with_beat: got wc=%h bc=%h lk=%b want 0 0 1111", word_count,
               bit_error_count, locked);
    end
  endtask

  task automatic test_reset_mid_lock();
    step(1'b1, 1'b0, 1'b1, '0);
    vectors++;
    if (locked !== '0 || word_count !== '0 || bit_error_count !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_lock: got lk=%b wc=%h bc=%h want 0", locked, word_count,
               bit_error_count);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    vectors++;
    if (locked !== '0 || word_count !== '0 || error_flag !== '0) begin
      miscompares++;
      $display("FAIL seed_after_reset: got lk=%b wc=%h ef=%b want 0", locked, word_count,
               error_flag);
    end
  endtask

  task automatic test_random();
    logic [32*NCH-1:0] xm;
    for (int i = 0; i < 600; i++) begin
      xm = '0;
      for (int j = 0; j < NCH; j++) begin
        if ($urandom_range(0, 11) == 0)
          xm[32*j +: 32] = ($urandom_range(0, 1) == 1) ? $urandom() : (32'h1 << $urandom_range(0, 31));
      end
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 299) == 0), xm);
    end
  endtask

  initial begin
    for (int j = 0; j < NCH; j++) gen[j] = 32'h1;
    test_reset();
    test_lock_acquire();
    test_bit_flip();
    test_unlock_relock();
    test_lane_isolation();
    test_gaps();
    test_saturation();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
